// File: rtl/score_bcd_accumulator.sv
// Three-digit BCD score accumulator: one digit per cycle with ripple carry, plus a one-entry pending request buffer.
// Optional macro SCORE_SATURATE_EN: saturate at 999 with a sticky score_max flag (default build wraps modulo 1000).
module score_bcd_accumulator (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       hit,
    input  logic [3:0] points,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic       busy,
    output logic       drop,
    output logic       score_max
);

    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {IDLE, ONES, TENS, HUNS} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] op_q, op_d;
    logic [DW-1:0] ones_q, ones_d;
    logic [DW-1:0] tens_q, tens_d;
    logic          carry_q, carry_d;
    logic [DW-1:0] pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic [DW-1:0] bcd1_q, bcd1_d;
    logic [DW-1:0] bcd2_q, bcd2_d;
    logic [DW-1:0] bcd3_q, bcd3_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;
    logic          max_q, max_d;
    logic [DW-1:0] hit_pts;
    logic [DW:0]   add_r;

    // One decimal digit add; returns {carry_out, digit}.
    function automatic logic [DW:0] bcd_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic cin);
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
        if (s > 5'd9) bcd_add = {1'b1, DW'(s - 5'd10)};
        else          bcd_add = {1'b0, s[DW-1:0]};
    endfunction

    assign hit_pts = (points > 4'd9) ? 4'd9 : points;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            ones_q     <= '0;
            tens_q     <= '0;
            carry_q    <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            bcd1_q     <= '0;
            bcd2_q     <= '0;
            bcd3_q     <= '0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            max_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ones_q     <= ones_d;
            tens_q     <= tens_d;
            carry_q    <= carry_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            bcd1_q     <= bcd1_d;
            bcd2_q     <= bcd2_d;
            bcd3_q     <= bcd3_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            max_q      <= max_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        carry_d    = carry_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        bcd1_d     = bcd1_q;
        bcd2_d     = bcd2_q;
        bcd3_d     = bcd3_q;
        drop_d     = 1'b0;
        add_r      = '0;
`ifdef SCORE_SATURATE_EN
        max_d      = max_q;
`else
        max_d      = 1'b0;
`endif

        if (clear) begin
            state_d    = IDLE;
            bcd1_d     = '0;
            bcd2_d     = '0;
            bcd3_d     = '0;
            pend_vld_d = 1'b0;
            max_d      = 1'b0;
        end else begin
            // Requests arriving mid-addition go to the buffer, or are dropped if it is full.
            if (hit && (state_q == ONES || state_q == TENS)) begin
                if (!pend_vld_q) begin
                    pend_vld_d = 1'b1;
                    pend_d     = hit_pts;
                end else begin
                    drop_d = 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (hit) begin
                        op_d    = hit_pts;
                        state_d = ONES;
                    end
                end
                ONES: begin
                    add_r   = bcd_add(bcd3_q, op_q, 1'b0);
                    ones_d  = add_r[DW-1:0];
                    carry_d = add_r[DW];
                    state_d = TENS;
                end
                TENS: begin
                    add_r   = bcd_add(bcd2_q, '0, carry_q);
                    tens_d  = add_r[DW-1:0];
                    carry_d = add_r[DW];
                    state_d = HUNS;
                end
                HUNS: begin
                    add_r = bcd_add(bcd1_q, '0, carry_q);
`ifdef SCORE_SATURATE_EN
                    if (add_r[DW]) begin
                        bcd1_d = 4'd9;
                        bcd2_d = 4'd9;
                        bcd3_d = 4'd9;
                    end else begin
                        bcd1_d = add_r[DW-1:0];
                        bcd2_d = tens_q;
                        bcd3_d = ones_q;
                    end
`else
                    bcd1_d = add_r[DW-1:0];
                    bcd2_d = tens_q;
                    bcd3_d = ones_q;
`endif
                    if (add_r[DW]) max_d = 1'b1;
                    // Chain straight into the next addition so the buffer never lingers in IDLE.
                    if (pend_vld_q) begin
                        op_d       = pend_q;
                        state_d    = ONES;
                        pend_vld_d = hit;
                        if (hit) pend_d = hit_pts;
                    end else if (hit) begin
                        op_d    = hit_pts;
                        state_d = ONES;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign bcd1      = bcd1_q;
    assign bcd2      = bcd2_q;
    assign bcd3      = bcd3_q;
    assign busy      = busy_q;
    assign drop      = drop_q;
    assign score_max = max_q;

endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Randomized and directed bench for score_bcd_accumulator against an integer-score reference model.
module tb_score_bcd_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       hit;
    logic [3:0] points;
    logic [3:0] bcd1, bcd2, bcd3;
    logic       busy, drop, score_max;

    int checks;
    int failures;

    // Reference model: integer score, cycles-to-commit countdown, queue as pending buffer.
    int m_score;
    int m_cnt;
    int m_op;
    int m_q[$];
    bit m_drop;
    bit m_max;

    score_bcd_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .hit       (hit),
        .points    (points),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .busy      (busy),
        .drop      (drop),
        .score_max (score_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_score = 0;
        m_cnt   = 0;
        m_op    = 0;
        m_q.delete();
        m_drop  = 0;
        m_max   = 0;
    endfunction

    function automatic void model_step(bit c, bit h, int p);
        int pc;
        int s;
        pc = (p > 9) ? 9 : p;
        if (c) begin
            model_reset();
            return;
        end
        m_drop = 0;
`ifndef SCORE_SATURATE_EN
        m_max = 0;
`endif
        if (m_cnt == 0) begin
            if (h) begin
                m_op  = pc;
                m_cnt = 3;
            end
        end else if (m_cnt == 1) begin
            s = m_score + m_op;
            if (s >= 1000) begin
                m_max = 1;
`ifdef SCORE_SATURATE_EN
                s = 999;
`else
                s = s - 1000;
`endif
            end
            m_score = s;
            if (m_q.size() != 0) begin
                m_op  = m_q.pop_front();
                m_cnt = 3;
                if (h) m_q.push_back(pc);
            end else if (h) begin
                m_op  = pc;
                m_cnt = 3;
            end else begin
                m_cnt = 0;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (h) begin
                if (m_q.size() == 0) m_q.push_back(pc);
                else m_drop = 1;
            end
        end
    endfunction

    function automatic logic [14:0] exp_vec();
        return {4'(m_score / 100), 4'((m_score / 10) % 10), 4'(m_score % 10),
                (m_cnt != 0), m_drop, m_max};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {bcd1, bcd2, bcd3, busy, drop, score_max};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it.
    task automatic tick(input bit c, input bit h, input int p);
        clear  = c;
        hit    = h;
        points = 4'(p);
        @(posedge clk);
        model_step(c, h, p);
        #1;
    endtask

    task automatic add(input int p);
        tick(0, 1, p);
        repeat (3) tick(0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        hit   = 1'b0;
        points = 4'd0;
        model_reset();
        #2;
        checks++;
        if (obs_vec() !== 15'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), 15'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        tick(0, 1, 5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b1 || drop !== 1'b0 || {bcd1, bcd2, bcd3} !== 12'h000) begin
                failures++;
                $display("FAIL single_busy c%0d got=%h exp busy=1 drop=0 000", i, obs_vec());
            end
            tick(0, 0, 0);
        end
        checks++;
        if ({bcd1, bcd2, bcd3, busy, drop} !== {12'h005, 2'b00}) begin
            failures++;
            $display("FAIL single_commit got=%h exp=%h", obs_vec(), {12'h005, 3'b000});
        end
    endtask

    task automatic test_ripple();
        tick(1, 0, 0);
        repeat (10) add(9);
        add(8);
        checks++;
        if ({bcd1, bcd2, bcd3} !== 12'h098) begin
            failures++;
            $display("FAIL ripple_setup got=%h exp=098", {bcd1, bcd2, bcd3});
        end
        tick(0, 1, 7);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({bcd1, bcd2, bcd3} !== 12'h098 || busy !== 1'b1) begin
                failures++;
                $display("FAIL ripple_hold c%0d got=%h exp=098 busy=1", i, obs_vec());
            end
            tick(0, 0, 0);
        end
        checks++;
        if ({bcd1, bcd2, bcd3, busy} !== {12'h105, 1'b0}) begin
            failures++;
            $display("FAIL ripple_commit got=%h exp=105 busy=0", obs_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic exp_drop;
        tick(1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 1, i);
            exp_drop = (i == 3);
            checks++;
            if (busy !== 1'b1 || drop !== exp_drop) begin
                failures++;
                $display("FAIL b2b_hit%0d got busy=%b drop=%b exp busy=1 drop=%b", i, busy, drop, exp_drop);
            end
        end
        for (int i = 3; i <= 6; i++) begin
            tick(0, 0, 0);
            checks++;
            if (busy !== (i != 6) || drop !== 1'b0) begin
                failures++;
                $display("FAIL b2b_edge%0d got busy=%b drop=%b exp busy=%b drop=0", i, busy, drop, (i != 6));
            end
        end
        checks++;
        if ({bcd1, bcd2, bcd3} !== 12'h003) begin
            failures++;
            $display("FAIL b2b_final got=%h exp=003", {bcd1, bcd2, bcd3});
        end
    endtask

    task automatic test_clamp();
        tick(1, 0, 0);
        add(15);
        checks++;
        if ({bcd1, bcd2, bcd3} !== 12'h009) begin
            failures++;
            $display("FAIL clamp got=%h exp=009", {bcd1, bcd2, bcd3});
        end
        tick(0, 1, 0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL zero_busy got=%b exp=1", busy);
        end
        repeat (3) tick(0, 0, 0);
        checks++;
        if ({bcd1, bcd2, bcd3, busy} !== {12'h009, 1'b0}) begin
            failures++;
            $display("FAIL zero_points got=%h exp=009 busy=0", obs_vec());
        end
    endtask

    task automatic test_overflow();
        tick(1, 0, 0);
        repeat (110) add(9);
        add(5);
        checks++;
        if ({bcd1, bcd2, bcd3} !== 12'h995) begin
            failures++;
            $display("FAIL ovf_setup got=%h exp=995", {bcd1, bcd2, bcd3});
        end
        add(7);
`ifdef SCORE_SATURATE_EN
        checks++;
        if ({bcd1, bcd2, bcd3, score_max} !== {12'h999, 1'b1}) begin
            failures++;
            $display("FAIL ovf_sat got=%h exp=999 max=1", obs_vec());
        end
        add(3);
        tick(0, 0, 0);
        checks++;
        if ({bcd1, bcd2, bcd3, score_max} !== {12'h999, 1'b1}) begin
            failures++;
            $display("FAIL ovf_sat_hold got=%h exp=999 max=1", obs_vec());
        end
        tick(1, 0, 0);
        checks++;
        if (score_max !== 1'b0) begin
            failures++;
            $display("FAIL ovf_sat_clear got=%b exp=0", score_max);
        end
`else
        checks++;
        if ({bcd1, bcd2, bcd3, score_max} !== {12'h002, 1'b1}) begin
            failures++;
            $display("FAIL ovf_wrap got=%h exp=002 max=1", obs_vec());
        end
        tick(0, 0, 0);
        checks++;
        if ({bcd1, bcd2, bcd3, score_max} !== {12'h002, 1'b0}) begin
            failures++;
            $display("FAIL ovf_wrap_pulse got=%h exp=002 max=0", obs_vec());
        end
`endif
    endtask

    task automatic test_clear();
        tick(1, 0, 0);
        add(2);
        tick(0, 1, 4);
        tick(0, 1, 5);
        tick(1, 1, 6);
        checks++;
        if (obs_vec() !== 15'd0) begin
            failures++;
            $display("FAIL clear_tens got=%h exp=%h", obs_vec(), 15'd0);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obs_vec() !== 15'd0) begin
                failures++;
                $display("FAIL clear_after c%0d got=%h exp=%h", i, obs_vec(), 15'd0);
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1, 0, 0);
        add(4);
        tick(0, 1, 6);
        tick(0, 0, 0);
        tick(0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== 15'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs_vec(), 15'd0);
        end
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL async_release c%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit c;
        bit h;
        int p;
        tick(1, 0, 0);
        for (int i = 0; i < 800; i++) begin
            c = ($urandom_range(0, 39) == 0);
            h = ($urandom_range(0, 9) < 6);
            p = $urandom_range(0, 15);
            tick(c, h, p);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random c%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_ripple();
        test_back_to_back();
        test_clamp();
        test_overflow();
        test_clear();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bcd_accumulator.md
SCORE_BCD_ACCUMULATOR -- requirements
Module: score_bcd_accumulator

Interface
REQ-001 Parameters: none; digit count fixed at 3 BCD digits (score range 000-999).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 clear  input  1  synchronous score clear, level-sampled.
REQ-005 hit  input  1  add request, sampled each edge; one request per high cycle.
REQ-006 points  input  4  BCD points for the request (0-9), sampled with hit.
REQ-007 bcd1  output  4  hundreds digit, registered, feeds display.
REQ-008 bcd2  output  4  tens digit, registered.
REQ-009 bcd3  output  4  ones digit, registered.
REQ-010 busy  output  1  high while an addition is in progress (state != IDLE).
REQ-011 drop  output  1  one-cycle pulse when a request is discarded.
REQ-012 score_max  output  1  overflow indication (see REQ-026/027).

Function
REQ-013 FSM states: IDLE, ONES, TENS, HUNS; one digit processed per cycle, ripple carry between states.
REQ-014 hit high in IDLE with pending buffer empty: points captured into the work operand; next state ONES.
REQ-015 ONES: ones = (bcd3 + operand) decimal-adjusted; carry to TENS. TENS: tens + carry. HUNS: hundreds + carry; all three outputs committed together on the HUNS edge; outputs never show a partial sum.
REQ-016 Latency: request accepted at edge k; bcd1..bcd3 updated at edge k+3; busy high from k through k+3.
REQ-017 points > 9 clamped to 9; points = 0 runs the full sequence with unchanged score.
REQ-018 One-entry pending buffer: hit while busy and buffer empty stores points; no drop.
REQ-019 hit while busy and buffer full: request discarded, drop high for exactly the next cycle; buffer unchanged.
REQ-020 On the commit (HUNS) edge with buffer valid: buffered points loaded as new operand, buffer emptied, next state ONES (no IDLE cycle).
REQ-021 hit on the commit edge with buffer full: buffer frees and takes the new request in the same edge; no drop.
REQ-022 hit in IDLE never sees a full buffer (buffer drains via REQ-020).
REQ-023 clear high: score to 000, buffer emptied, FSM to IDLE, score_max to 0, drop to 0; hit in same cycle ignored without drop; clear overrides all other events.
REQ-024 Digits always valid BCD (0-9); any non-BCD internal value is a design error.

Reset
REQ-025 rst_n low: bcd1=bcd2=bcd3=0, busy=0, drop=0, score_max=0, buffer empty, FSM IDLE, immediately and independent of clk; mid-addition reset abandons the operation, no partial commit; release takes effect on the next edge with FSM in IDLE.

Configuration
REQ-026 Macro SCORE_SATURATE_EN defined: carry out of hundreds on commit forces score 999; score_max set and held high until clear or reset; further requests still accepted and leave 999.
REQ-027 Macro undefined: score wraps modulo 1000 (e.g. 995+7 -> 002); score_max pulses high for one cycle after each wrapping commit.

Verification
REQ-028 Reset, then hit=1 points=5 one cycle -> busy high 3 cycles, outputs 0,0,5 at edge k+3, drop never pulses.
REQ-029 Score 098, hit points=7 -> commit 1,0,5 (double ripple carry); bcd outputs stay 0,9,8 until commit edge.
REQ-030 Three back-to-back hits points=1,2,3 from 000 -> first accepted, second buffered, third dropped (drop one cycle); final score 003 after 6 cycles, busy continuous.
REQ-031 Score 995, hit points=7 -> with SCORE_SATURATE_EN 999 and score_max held high; without it 002 and score_max single-cycle pulse.
REQ-032 Assert clear during TENS with buffer full -> next edge 000, busy 0, buffer empty, no commit; rst_n low mid-HUNS -> outputs 000 immediately without a clk edge.
